coax_rx_frame: RTL and testbench

COAX_RX_FRAME -- requirements
Module: coax_rx_frame

---
 rtl/coax_rx_frame.sv | 201 ++++++++++++++++++++
 tb/tb_coax_rx_frame.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_frame.sv
// coax_rx_frame: frames coax receiver words into a FIFO of {last, word}.
// Optional idle timeout: define COAX_RX_FRAME_TIMEOUT_EN.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_active           - receiver frame-in-progress level
//   rx_data_available   - strobe, rx_data valid
//   rx_data[9:0]        - received word
//   rx_error            - strobe, line/parity error
//   read_strobe         - pop head entry
//   read_data[9:0]      - head word (fall-through)
//   read_last           - head word ends its frame
//   empty, busy         - FIFO empty / FSM not idle
//   frame_count[7:0]    - completed frames pushed (wraps)
//   overflow, error     - sticky drop / abort flags
module coax_rx_frame #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_data_available,
  input  logic [9:0] rx_data,
  input  logic       rx_error,
  input  logic       read_strobe,
  output logic [9:0] read_data,
  output logic       read_last,
  output logic       empty,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       overflow,
  output logic       error
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 4 || DEPTH > 256 || (1 << AW) != DEPTH)
      $error("DEPTH must be a power of 2 in 4..256");
    if (TIMEOUT_CYCLES < 1)
      $error("TIMEOUT_CYCLES must be at least 1");
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    DISCARD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [9:0] staged;
  logic [9:0] staged_nxt;
  logic       staged_valid;
  logic       staged_valid_nxt;

  logic [10:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;

  logic        push_req;
  logic        push_last;
  logic        push_ok;
  logic        drop;
  logic        set_err;
  logic        timeout;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = read_strobe && !empty;

  // A pop in the same cycle frees the slot, so a full push still lands.
  assign push_ok = push_req && (!full || read_strobe);
  assign drop    = push_req && !push_ok;

  assign {read_last, read_data} = mem[rd_ptr[AW-1:0]];
  assign busy = (state != IDLE);

`ifdef COAX_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  assign timeout = (state == RECEIVE) && !rx_data_available &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state == RECEIVE && !rx_data_available && !timeout) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    staged_nxt       = staged;
    staged_valid_nxt = staged_valid;
    push_req         = 1'b0;
    push_last        = 1'b0;
    set_err          = 1'b0;
    unique case (state)
      IDLE: begin
        // A word strobed on the falling cycle is still staged here;
        // it closes the previous frame.
        if (staged_valid) begin
          push_req  = 1'b1;
          push_last = 1'b1;
        end
        staged_valid_nxt = 1'b0;
        if (rx_active) begin
          state_nxt = RECEIVE;
        end
      end
      RECEIVE: begin
        if (rx_error || timeout) begin
          push_req         = staged_valid;
          push_last        = 1'b1;
          set_err          = 1'b1;
          staged_valid_nxt = 1'b0;
          state_nxt        = DISCARD;
        end else if (rx_data_available) begin
          push_req         = staged_valid;
          staged_nxt       = rx_data;
          staged_valid_nxt = 1'b1;
          if (!rx_active) begin
            state_nxt = IDLE;
          end
        end else if (!rx_active) begin
          push_req         = staged_valid;
          push_last        = 1'b1;
          staged_valid_nxt = 1'b0;
          state_nxt        = IDLE;
        end
        if (drop) begin
          staged_valid_nxt = 1'b0;
          state_nxt        = DISCARD;
        end
      end
      DISCARD: begin
        staged_valid_nxt = 1'b0;
        if (!rx_active) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        staged_valid_nxt = 1'b0;
        state_nxt        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      staged       <= '0;
      staged_valid <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      frame_count  <= '0;
      overflow     <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      staged       <= staged_nxt;
      staged_valid <= staged_valid_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && push_last) begin
        frame_count <= frame_count + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (set_err) begin
        error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {push_last, staged};
    end
  end

endmodule

// File: tb/tb_coax_rx_frame.sv
// tb_coax_rx_frame: randomized self-checking bench for coax_rx_frame.
// Frame-level reference model of the FIFO contents and status flags.
module tb_coax_rx_frame;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_active;
  logic       rx_data_available;
  logic [9:0] rx_data;
  logic       rx_error;
  logic       read_strobe;
  logic [9:0] read_data;
  logic       read_last;
  logic       empty;
  logic       busy;
  logic [7:0] frame_count;
  logic       overflow;
  logic       error;

  coax_rx_frame #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_active(rx_active),
    .rx_data_available(rx_data_available),
    .rx_data(rx_data),
    .rx_error(rx_error),
    .read_strobe(read_strobe),
    .read_data(read_data),
    .read_last(read_last),
    .empty(empty),
    .busy(busy),
    .frame_count(frame_count),
    .overflow(overflow),
    .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [10:0] q[$];
  logic [9:0]  words[$];
  int          exp_count;
  bit          exp_ovf;
  bit          exp_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(10'($urandom));
  endtask

  // Frame-level rules: a frame that fits is stored whole with last on
  // its final word and counted; one that does not fit keeps only the
  // words that fit, none flagged last, and is not counted.
  task automatic model_frame(input int off, input int n, input bit err);
    int free;
    free = DEPTH - q.size();
    if (n > 0) begin
      if (n <= free) begin
        for (int i = 0; i < n; i++)
          q.push_back({(i == n - 1) ? 1'b1 : 1'b0, words[off + i]});
        exp_count = (exp_count + 1) % 256;
      end else begin
        for (int i = 0; i < free; i++)
          q.push_back({1'b0, words[off + i]});
        exp_ovf = 1'b1;
      end
    end
    if (err && n <= free) exp_err = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_active = 1'b0;
    rx_data_available = 1'b0;
    rx_data = '0;
    rx_error = 1'b0;
    read_strobe = 1'b0;
    step();
    reset = 1'b0;
    q.delete();
    exp_count = 0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] w, input bit fall);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) step();
    rx_data = w;
    rx_data_available = 1'b1;
    if (fall) rx_active = 1'b0;
    step();
    rx_data_available = 1'b0;
  endtask

  task automatic send_frame(input int off, input int n, input bit fall);
    rx_active = 1'b1;
    step();
    for (int i = 0; i < n; i++)
      send_word(words[off + i], fall && (i == n - 1));
    rx_active = 1'b0;
    repeat (3) step();
    model_frame(off, n, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (empty !== 1'b0) begin
        errors++;
        $display("FAIL %s empty_early: got empty=%b at entry %0d, want 0",
                 name, empty, i);
      end else begin
        checks++;
        if ({read_last, read_data} !== q[i]) begin
          errors++;
          $display("FAIL %s entry%0d: got last=%b data=%h want last=%b data=%h",
                   name, i, read_last, read_data, q[i][10], q[i][9:0]);
        end
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL %s empty_after: got %b want 1", name, empty);
    end
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_active = 1'b1;
    rx_data_available = 1'b1;
    rx_data = 10'h155;
    rx_error = 1'b0;
    read_strobe = 1'b1;
    step();
    checks++;
    if ({empty, busy, frame_count, overflow, error} !==
        {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got e=%b b=%b fc=%0d o=%b er=%b want 1 0 0 0 0",
               empty, busy, frame_count, overflow, error);
    end
    do_reset();
    step();
  endtask

  task automatic test_spec_frame();
    gen_words(12);
    words[0] = 10'h031;
    words[1] = 10'h29C;
    words[2] = 10'h212;
    words[11] = 10'h20C;
    send_frame(0, 12, 1'b0);
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL spec_count: got %0d want %0d", frame_count, exp_count);
    end
    drain("spec_frame");
  endtask

  task automatic test_random_frames();
    repeat (8) begin
      int n;
      bit fall;
      n = $urandom_range(1, 6);
      fall = 1'($urandom);
      gen_words(n);
      send_frame(0, n, fall);
      checks++;
      if (frame_count !== 8'(exp_count)) begin
        errors++;
        $display("FAIL rand_count: got %0d want %0d", frame_count, exp_count);
      end
      drain("random_frame");
    end
  endtask

  task automatic test_read_empty();
    read_strobe = 1'b1;
    repeat (3) step();
    read_strobe = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL read_empty: got empty=%b want 1", empty);
    end
    gen_words(2);
    send_frame(0, 2, 1'b0);
    drain("after_read_empty");
  endtask

  task automatic test_zero_frame();
    rx_active = 1'b1;
    repeat (3) step();
    rx_active = 1'b0;
    repeat (2) step();
    checks++;
    if (empty !== 1'b1 || frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL zero_frame: got empty=%b fc=%0d want 1 %0d",
               empty, frame_count, exp_count);
    end
  endtask

  task automatic test_fall_strobe();
    gen_words(3);
    send_frame(0, 3, 1'b1);
    drain("fall_strobe");
  endtask

  task automatic test_back_to_back();
    gen_words(5);
    rx_active = 1'b1;
    step();
    send_word(words[0], 1'b0);
    send_word(words[1], 1'b1);
    rx_active = 1'b1;
    step();
    for (int i = 2; i < 5; i++) send_word(words[i], 1'b0);
    rx_active = 1'b0;
    repeat (3) step();
    model_frame(0, 2, 1'b0);
    model_frame(2, 3, 1'b0);
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count);
    end
    drain("back_to_back");
  endtask

  task automatic test_overflow();
    do_reset();
    gen_words(20);
    rx_active = 1'b1;
    step();
    for (int i = 0; i < 20; i++) send_word(words[i], 1'b0);
    step();
    checks++;
    if (busy !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_discard: got busy=%b ovf=%b want 1 1", busy, overflow);
    end
    rx_active = 1'b0;
    repeat (2) step();
    model_frame(0, 20, 1'b0);
    checks++;
    if (busy !== 1'b0 || frame_count !== 8'(exp_count) ||
        overflow !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_end: got busy=%b fc=%0d ovf=%b want 0 %0d %b",
               busy, frame_count, overflow, exp_count, exp_ovf);
    end
    drain("overflow");
  endtask

  task automatic test_full_rw();
    logic [9:0] b0;
    logic [9:0] b1;
    do_reset();
    gen_words(16);
    send_frame(0, 16, 1'b0);
    b0 = 10'($urandom);
    b1 = 10'($urandom);
    rx_active = 1'b1;
    step();
    rx_data = b0;
    rx_data_available = 1'b1;
    step();
    rx_data = b1;
    read_strobe = 1'b1;
    step();
    rx_data_available = 1'b0;
    read_strobe = 1'b0;
    void'(q.pop_front());
    q.push_back({1'b0, b0});
    rx_active = 1'b0;
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    void'(q.pop_front());
    q.push_back({1'b1, b1});
    exp_count = (exp_count + 1) % 256;
    repeat (2) step();
    checks++;
    if (overflow !== 1'b0 || frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL full_rw: got ovf=%b fc=%0d want 0 %0d",
               overflow, frame_count, exp_count);
    end
    drain("full_rw");
  endtask

  task automatic test_error();
    do_reset();
    gen_words(5);
    rx_active = 1'b1;
    step();
    for (int i = 0; i < 3; i++) send_word(words[i], 1'b0);
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    for (int i = 3; i < 5; i++) send_word(words[i], 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL err_discard: got busy=%b want 1", busy);
    end
    rx_active = 1'b0;
    repeat (2) step();
    model_frame(0, 3, 1'b1);
    checks++;
    if (error !== exp_err || frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL err_flags: got err=%b fc=%0d want %b %0d",
               error, frame_count, exp_err, exp_count);
    end
    drain("error");
  endtask

  task automatic test_reset_mid();
    gen_words(3);
    rx_active = 1'b1;
    step();
    for (int i = 0; i < 3; i++) send_word(words[i], 1'b0);
    reset = 1'b1;
    rx_data_available = 1'b1;
    rx_error = 1'b1;
    step();
    reset = 1'b0;
    rx_data_available = 1'b0;
    rx_error = 1'b0;
    q.delete();
    exp_count = 0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    checks++;
    if ({empty, busy, frame_count, overflow, error} !==
        {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got e=%b b=%b fc=%0d o=%b er=%b want 1 0 0 0 0",
               empty, busy, frame_count, overflow, error);
    end
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: got busy=%b want 1", busy);
    end
    gen_words(2);
    send_frame(0, 2, 1'b0);
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL restart_count: got %0d want %0d", frame_count, exp_count);
    end
    drain("reset_mid");
  endtask

  task automatic test_timeout();
    do_reset();
    gen_words(2);
    rx_active = 1'b1;
    step();
    for (int i = 0; i < 2; i++) send_word(words[i], 1'b0);
    repeat (TO) step();
`ifdef COAX_RX_FRAME_TIMEOUT_EN
    model_frame(0, 2, 1'b1);
`endif
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL timeout_err: got %b want %b", error, exp_err);
    end
    rx_active = 1'b0;
    repeat (3) step();
`ifndef COAX_RX_FRAME_TIMEOUT_EN
    model_frame(0, 2, 1'b0);
`endif
    checks++;
    if (frame_count !== 8'(exp_count) || error !== exp_err) begin
      errors++;
      $display("FAIL timeout_end: got fc=%0d err=%b want %0d %b",
               frame_count, error, exp_count, exp_err);
    end
    drain("timeout");
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_random_frames();
    test_read_empty();
    test_zero_frame();
    test_fall_strobe();
    test_back_to_back();
    test_overflow();
    test_full_rw();
    test_error();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
